gate_identifier: RTL and testbench

//  Stimulus and response checker for a 2-input gate under test (GUT).

---
 rtl/gate_identifier.sv | 119 +++++++++++
 tb/tb_gate_identifier.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_identifier.sv
// Drives a 2-input gate through all four input vectors, records its truth table over
// one or more sweeps, and decodes the table into a gate function code.
module gate_identifier #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned REPEAT        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       drv_a,
    output logic       drv_b,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic [2:0] gate_code,
    output logic       mismatch
);
    localparam int unsigned SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEC,
        S_CLASSIFY,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [SW-1:0] r_settle;
    logic [1:0]  r_k;
    logic [3:0]  r_sweep;
    logic [2:0]  w_code;
    logic [1:0]  w_next_k;

    assign w_next_k = r_k + 2'd1;

    always_comb begin
        w_code = 3'd0;
        case (truth_table)
            4'b1000: w_code = 3'd1;
            4'b1110: w_code = 3'd2;
            4'b0111: w_code = 3'd3;
            4'b0001: w_code = 3'd4;
            4'b0110: w_code = 3'd5;
            4'b1001: w_code = 3'd6;
            4'b0011: w_code = 3'd7;
            default: w_code = 3'd0;
        endcase
        if (mismatch) w_code = 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_k         <= '0;
            r_sweep     <= '0;
            drv_a       <= 1'b0;
            drv_b       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            gate_code   <= '0;
            mismatch    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        truth_table <= '0;
                        gate_code   <= '0;
                        mismatch    <= 1'b0;
                        drv_a       <= 1'b0;
                        drv_b       <= 1'b0;
                        busy        <= 1'b1;
                        r_k         <= '0;
                        r_sweep     <= '0;
                        r_settle    <= '0;
                        r_state     <= S_VEC;
                    end
                end
                S_VEC: begin
                    if (r_settle == SW'(SETTLE_CYCLES)) begin
                        r_settle <= '0;
                        // Sweep 0 records the table; later sweeps only compare against it.
                        if (r_sweep == 4'd0)
                            truth_table[r_k] <= y_in;
                        else if (y_in != truth_table[r_k])
                            mismatch <= 1'b1;
                        r_k   <= w_next_k;
                        drv_a <= w_next_k[1];
                        drv_b <= w_next_k[0];
                        if (r_k == 2'd3) begin
                            if (r_sweep == 4'(REPEAT - 1))
                                r_state <= S_CLASSIFY;
                            else
                                r_sweep <= r_sweep + 4'd1;
                        end
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                S_CLASSIFY: begin
                    drv_a     <= 1'b0;
                    drv_b     <= 1'b0;
                    gate_code <= w_code;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_identifier.sv
// Scoreboard bench: drivers queue expected results per run, a monitor checks them on done.
module tb_gate_identifier;
    typedef struct {
        logic [3:0]  tt;
        logic [2:0]  code;
        logic        mm;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start2 = 1'b0;
    logic drv_a1, drv_b1, y1, busy1, done1, mm1;
    logic drv_a2, drv_b2, y2, busy2, done2, mm2;
    logic [3:0] tt1, tt2;
    logic [2:0] code1, code2;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int mode1 = 0;
    int mode2 = 0;
    logic flip2 = 1'b0;
    int t0_2 = 0;
    logic prev_done1 = 1'b0, prev_done2 = 1'b0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0 AND 1 OR 2 NAND 3 NOR 4 XOR 5 XNOR 6 NOT-a 7 constant 1
    function automatic logic gate(int m, logic a, logic b);
        case (m)
            0: return a & b;
            1: return a | b;
            2: return ~(a & b);
            3: return ~(a | b);
            4: return a ^ b;
            5: return ~(a ^ b);
            6: return ~a;
            default: return 1'b1;
        endcase
    endfunction

    assign y1 = gate(mode1, drv_a1, drv_b1);
    assign y2 = (flip2 && (cyc - t0_2) >= 13) ? gate(1, drv_a2, drv_b2) : gate(0, drv_a2, drv_b2);

    gate_identifier #(.SETTLE_CYCLES(2), .REPEAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .drv_a(drv_a1), .drv_b(drv_b1),
        .y_in(y1), .busy(busy1), .done(done1), .truth_table(tt1), .gate_code(code1),
        .mismatch(mm1)
    );

    gate_identifier #(.SETTLE_CYCLES(2), .REPEAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .drv_a(drv_a2), .drv_b(drv_b2),
        .y_in(y2), .busy(busy2), .done(done2), .truth_table(tt2), .gate_code(code2),
        .mismatch(mm2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the oldest expectation whenever a done pulse appears.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (prev_done1) chk("dut1 done width", int'(done1), 0);
        if (done1) begin
            if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
            else begin
                e = q1.pop_front();
                chk("dut1 truth_table", int'(tt1), int'(e.tt));
                chk("dut1 gate_code", int'(code1), int'(e.code));
                chk("dut1 mismatch", int'(mm1), int'(e.mm));
                chk("dut1 done cycle", cyc, e.cyc);
                chk("dut1 busy at done", int'(busy1), 0);
            end
        end
        if (prev_done2) chk("dut2 done width", int'(done2), 0);
        if (done2) begin
            if (q2.size() == 0) chk("dut2 unexpected done", 1, 0);
            else begin
                e = q2.pop_front();
                chk("dut2 truth_table", int'(tt2), int'(e.tt));
                chk("dut2 gate_code", int'(code2), int'(e.code));
                chk("dut2 mismatch", int'(mm2), int'(e.mm));
                chk("dut2 done cycle", cyc, e.cyc);
            end
        end
        prev_done1 = done1;
        prev_done2 = done2;
    end

    task automatic wait_idle1();
        for (int i = 0; i < 200; i++) begin
            wait_edges(1);
            if (q1.size() == 0 && !busy1 && !done1) return;
        end
        chk("dut1 run timeout", 1, 0);
        q1.delete();
    endtask

    task automatic wait_idle2();
        for (int i = 0; i < 200; i++) begin
            wait_edges(1);
            if (q2.size() == 0 && !busy2 && !done2) return;
        end
        chk("dut2 run timeout", 1, 0);
        q2.delete();
    endtask

    // Pulse start on dut1 and queue the expected result; returns the cycle stamp of T0.
    task automatic launch1(input int m, input logic [3:0] tt, input logic [2:0] code, output int t0);
        exp_t e;
        mode1 = m;
        @(negedge clk) start1 = 1'b1;
        wait_edges(1);
        t0 = cyc;
        e.tt = tt; e.code = code; e.mm = 1'b0; e.cyc = t0 + 13;
        q1.push_back(e);
        @(negedge clk) start1 = 1'b0;
    endtask

    task automatic run1(input int m, input logic [3:0] tt, input logic [2:0] code);
        int t0;
        launch1(m, tt, code, t0);
        wait_idle1();
    endtask

    task automatic run2(input logic flip, input logic [3:0] tt, input logic [2:0] code, input logic mm);
        exp_t e;
        flip2 = flip;
        @(negedge clk) start2 = 1'b1;
        wait_edges(1);
        t0_2 = cyc;
        e.tt = tt; e.code = code; e.mm = mm; e.cyc = t0_2 + 25;
        q2.push_back(e);
        @(negedge clk) start2 = 1'b0;
        wait_idle2();
    endtask

    initial begin
        int t0;
        exp_t e;
        #23;
        chk("reset busy", int'(busy1), 0);
        chk("reset done", int'(done1), 0);
        chk("reset drv", int'({drv_a1, drv_b1}), 0);
        chk("reset results", int'({tt1, code1, mm1}), 0);
        @(negedge clk) rst_n = 1'b1;

        // AND with drive sequence and latency
        launch1(0, 4'b1000, 3'd1, t0);
        wait_edges(t0 + 2 - cyc);
        chk("drv vec0", int'({drv_a1, drv_b1}), 0);
        chk("busy during run", int'(busy1), 1);
        wait_edges(2);
        chk("drv vec1", int'({drv_a1, drv_b1}), 1);
        wait_edges(3);
        chk("drv vec2", int'({drv_a1, drv_b1}), 2);
        wait_edges(3);
        chk("drv vec3", int'({drv_a1, drv_b1}), 3);
        wait_edges(3);
        chk("drv classify", int'({drv_a1, drv_b1}), 0);
        wait_idle1();

        run1(4, 4'b0110, 3'd5);
        run1(5, 4'b1001, 3'd6);
        run1(1, 4'b1110, 3'd2);
        run1(2, 4'b0111, 3'd3);
        run1(3, 4'b0001, 3'd4);
        run1(6, 4'b0011, 3'd7);
        run1(7, 4'b1111, 3'd0);

        // REPEAT=2: consistent AND, then AND turning into OR on the second sweep
        run2(1'b0, 4'b1000, 3'd1, 1'b0);
        run2(1'b1, 4'b1000, 3'd0, 1'b1);

        // Reset during vector 2 of an OR run
        mode1 = 1;
        @(negedge clk) start1 = 1'b1;
        wait_edges(1);
        t0 = cyc;
        @(negedge clk) start1 = 1'b0;
        wait_edges(t0 + 7 - cyc);
        chk("pre-reset drv vec2", int'({drv_a1, drv_b1}), 2);
        chk("pre-reset partial table", int'(tt1), 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("midrun reset busy", int'(busy1), 0);
        chk("midrun reset done", int'(done1), 0);
        chk("midrun reset drv", int'({drv_a1, drv_b1}), 0);
        chk("midrun reset results", int'({tt1, code1, mm1}), 0);
        @(negedge clk) rst_n = 1'b1;
        run1(1, 4'b1110, 3'd2);

        // start re-pulsed while busy, then held high across DONE
        launch1(0, 4'b1000, 3'd1, t0);
        wait_edges(t0 + 5 - cyc);
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        wait_edges(t0 + 11 - cyc);
        start1 = 1'b1;
        e.tt = 4'b1000; e.code = 3'd1; e.mm = 1'b0; e.cyc = t0 + 28;
        q1.push_back(e);
        wait_edges(t0 + 14 - cyc);
        chk("busy low in DONE cycle", int'(busy1), 0);
        wait_edges(1);
        chk("restart after DONE", int'(busy1), 1);
        @(negedge clk) start1 = 1'b0;
        wait_idle1();

        wait_edges(3);
        chk("dut1 queue drained", q1.size(), 0);
        chk("dut2 queue drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
